// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity mode codes.
// The receiver uses the same parity codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// i_clear holds the counter at zero so the first bit after a start is full length.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == TERM) && !i_clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB-first, optional parity, 1 or 2 stop bits.
// All outputs come straight from registers.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_done,
  output logic       o_tx_busy,
  output logic       o_tx_serial
);

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  // Handshake: i_tx_start is a request that is honoured only while o_tx_done=1
  // (state IDLE); the accepting edge drops o_tx_done, and strobes seen while busy are dropped.
  uart_tx_state_t state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       par_bit, par_bit_n;
  logic       stop_cnt, stop_cnt_n;
  logic       serial_q, serial_n;
  logic       done_q, done_n;
  logic       tick;
  logic [7:0] data_m;

  assign data_m = i_tx_data & DATA_MASK;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(state == IDLE),
    .o_tick (tick)
  );

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    par_bit_n  = par_bit;
    stop_cnt_n = stop_cnt;
    serial_n   = serial_q;
    done_n     = done_q;
    case (state)
      IDLE: begin
        serial_n = 1'b1;
        done_n   = 1'b1;
        if (i_tx_start) begin
          shreg_n    = data_m;
          par_bit_n  = (PARITY == PAR_ODD) ? ~^data_m : ^data_m;
          bit_idx_n  = '0;
          stop_cnt_n = 1'b0;
          state_n    = START;
          serial_n   = 1'b0;
          done_n     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n  = DATA;
          serial_n = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_IDX) begin
            if (PARITY != PAR_NONE) begin
              state_n  = uart_pkg::PARITY;
              serial_n = par_bit;
            end else begin
              state_n  = STOP;
              serial_n = 1'b1;
            end
          end else begin
            // Line is registered, so the next bit is the one about to reach shreg[0].
            shreg_n   = shreg >> 1;
            serial_n  = shreg[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tick) begin
          state_n  = STOP;
          serial_n = 1'b1;
        end
      end
      STOP: begin
        serial_n = 1'b1;
        if (tick) begin
          if (STOP_BITS == 2 && !stop_cnt) begin
            stop_cnt_n = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        done_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b1;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      par_bit  <= par_bit_n;
      stop_cnt <= stop_cnt_n;
      serial_q <= serial_n;
      done_q   <= done_n;
    end
  end

  assign o_tx_serial = serial_q;
  assign o_tx_done   = done_q;
  assign o_tx_busy   = ~done_q;

endmodule
